data_ram_slave: RTL and testbench

- Responder for the MEM-stage load/store request interface: the MEM stage initiates, this block answers.
- Holds a word-addressed data memory, applies a fixed configurable wait-state latency and returns read data with a one-cycle ack.
- Raises stallreq_o while an access is outstanding so the pipeline controller freezes the EX/MEM pipeline register and earlier stages.
- Sits beside the MEM stage; stallreq_o feeds the pipeline control module.

---
 rtl/data_ram_slave_pkg.sv | 18 +
 rtl/data_ram_slave_array.sv | 31 +++
 rtl/data_ram_slave.sv | 147 ++++++++++++++
 tb/tb_data_ram_slave.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_slave_pkg.sv
// Shared definitions for the MEM-stage data RAM responder: FSM encodings,
// legacy constants and the default memory geometry.
package data_ram_slave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic        RstEnable = 1'b1;
  localparam logic        Stop      = 1'b1;

  localparam int DATA_MEM_DEPTH  = 1024;
  localparam int DATA_MEM_ADDR_W = 10;

endpackage

// File: rtl/data_ram_slave_array.sv
// DEPTH x 32 data storage: synchronous byte-enabled write and registered read.
// Contents are deliberately never reset.
module data_ram_array #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [3:0]        sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (sel[k]) begin
          mem[addr][8*k +: 8] <= wdata[8*k +: 8];
        end
      end
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_ram_slave.sv
// MEM-stage load/store responder with fixed wait-state latency and stall request.
// Optional range checking of upper address bits: define DATA_RAM_RANGE_ERR_EN.
module data_ram_slave
  import data_ram_slave_pkg::*;
#(
  parameter int DEPTH       = DATA_MEM_DEPTH,
  parameter int ADDR_W      = DATA_MEM_ADDR_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        stallreq_o
`ifdef DATA_RAM_RANGE_ERR_EN
  ,
  output logic        err_o
`endif
);

  state_t            state, next_state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] idx_q;
  logic              we_q;
  logic [3:0]        sel_q;
  logic [31:0]       data_q;
  logic              err_q;
  logic              in_err;
  logic [ADDR_W-1:0] acc_idx;
  logic              acc_we;
  logic [3:0]        acc_sel;
  logic [31:0]       acc_data;
  logic              acc_err;
  logic              enter_done;
  logic              out_zero;
  logic              err_r;
  logic [31:0]       ram_q;

`ifdef DATA_RAM_RANGE_ERR_EN
  logic unused_addr_bits;
  assign in_err           = |addr_i[31:ADDR_W+2];
  assign unused_addr_bits = ^addr_i[1:0];
  assign err_o            = err_r;
`else
  logic unused_addr_bits;
  assign in_err           = 1'b0;
  assign unused_addr_bits = ^{addr_i[31:ADDR_W+2], addr_i[1:0], err_r};
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (ce_i) begin
          next_state = (WAIT_CYCLES > 0) ? WAIT : DONE;
        end
      end
      WAIT: begin
        if (!ce_i) begin
          next_state = IDLE;
        end else if (cnt == 4'd1) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // With zero wait states DONE is entered straight from IDLE, before the
  // request fields have been latched, so the access uses the live inputs.
  always_comb begin
    acc_idx  = idx_q;
    acc_we   = we_q;
    acc_sel  = sel_q;
    acc_data = data_q;
    acc_err  = err_q;
    if (state == IDLE) begin
      acc_idx  = addr_i[ADDR_W+1:2];
      acc_we   = we_i;
      acc_sel  = sel_i;
      acc_data = data_i;
      acc_err  = in_err;
    end
  end

  assign enter_done = (next_state == DONE) && !rst;

  data_ram_array #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .we   (enter_done && acc_we && !acc_err),
    .re   (enter_done && !acc_we && !acc_err),
    .sel  (acc_sel),
    .addr (acc_idx),
    .wdata(acc_data),
    .rdata(ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      ack_o    <= 1'b0;
      out_zero <= 1'b1;
      err_r    <= 1'b0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= 4'd0;
      data_q   <= ZeroWord;
      err_q    <= 1'b0;
    end else begin
      state <= next_state;
      ack_o <= enter_done;
      err_r <= enter_done && acc_err;
      if (state == IDLE && ce_i) begin
        idx_q  <= addr_i[ADDR_W+1:2];
        we_q   <= we_i;
        sel_q  <= sel_i;
        data_q <= data_i;
        err_q  <= in_err;
        cnt    <= 4'(WAIT_CYCLES);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      // data_o is the registered RAM word unless forced to zero; stores leave it alone.
      if (enter_done) begin
        if (acc_err) begin
          out_zero <= 1'b1;
        end else if (!acc_we) begin
          out_zero <= 1'b0;
        end
      end
    end
  end

  assign data_o     = out_zero ? ZeroWord : ram_q;
  assign stallreq_o = ce_i & ~ack_o;

endmodule

// File: tb/tb_data_ram_slave.sv
// Scoreboard bench for data_ram_slave: random and directed loads/stores against a
// word-array model, plus a zero-wait-state instance for back-to-back timing.
module tb_data_ram_slave;

  localparam int W_A    = 2;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ce_a, we_a, ack_a, stall_a;
  logic [31:0] addr_a, data_a, dout_a;
  logic [3:0]  sel_a;
  logic        ce_b, we_b, ack_b, stall_b;
  logic [31:0] addr_b, data_b, dout_b;
  logic [3:0]  sel_b;
`ifdef DATA_RAM_RANGE_ERR_EN
  logic        err_a, err_b;
`endif

  data_ram_slave #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_CYCLES(W_A)) dut_a (
    .clk(clk), .rst(rst), .ce_i(ce_a), .we_i(we_a), .addr_i(addr_a), .sel_i(sel_a),
    .data_i(data_a), .data_o(dout_a), .ack_o(ack_a), .stallreq_o(stall_a)
`ifdef DATA_RAM_RANGE_ERR_EN
    , .err_o(err_a)
`endif
  );

  data_ram_slave #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .ce_i(ce_b), .we_i(we_b), .addr_i(addr_b), .sel_i(sel_b),
    .data_i(data_b), .data_o(dout_b), .ack_o(ack_b), .stallreq_o(stall_b)
`ifdef DATA_RAM_RANGE_ERR_EN
    , .err_o(err_b)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          edge_no;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [DEPTH];
  logic [31:0] last_data = 32'h0;
  int          last_ack = -10;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic bit rangeBad(input logic [31:0] a);
`ifdef DATA_RAM_RANGE_ERR_EN
    return a[31:ADDR_W+2] != '0;
`else
    return 1'b0;
`endif
  endfunction

  // mode 0: normal access, 1: flush while waiting, 2: reset while waiting
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                               input logic [31:0] data, input int gap, input int mode);
    exp_t e;
    int   n;
    int   idx;
    bit   bad;
    bit   got;
    if (gap > 0) begin
      ce_a = 1'b0;
      repeat (gap) @(negedge clk);
    end
    ce_a = 1'b1; we_a = we; addr_a = addr; sel_a = sel; data_a = data;
    n   = (cyc + 1 > last_ack + 2) ? cyc + 1 : last_ack + 2;
    idx = int'(addr[ADDR_W+1:2]);
    bad = rangeBad(addr);
    if (mode == 0) begin
      if (bad) begin
        last_data = 32'h0;
      end else if (we) begin
        for (int k = 0; k < 4; k++) begin
          if (sel[k]) model_mem[idx][8*k +: 8] = data[8*k +: 8];
        end
      end else begin
        last_data = model_mem[idx];
      end
      e.data = last_data; e.err = bad; e.edge_no = n + W_A;
      sb.push_back(e);
      got = 1'b0;
      for (int i = 0; i < W_A + 8 && !got; i++) begin
        @(negedge clk);
        if (ack_a) got = 1'b1;
        else checkOutput("stall_wait", {31'd0, stall_a}, 32'd1);
      end
      if (!got) begin
        checks++; errors++;
        $display("[TB] FAIL ack_timeout: no ack at edge %0d, expected one by edge %0d", cyc, n + W_A);
      end else begin
        last_ack = cyc;
      end
    end else begin
      @(negedge clk);
      checkOutput("stall_pending", {31'd0, stall_a}, 32'd1);
      ce_a = 1'b0;
      if (mode == 2) rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      if (mode == 2) begin
        checkOutput("rst_ack", {31'd0, ack_a}, 32'd0);
        checkOutput("rst_data", dout_a, 32'd0);
        last_data = 32'h0;
      end
      repeat (W_A + 3) @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    exp_t m;
    if (!rst && ack_a) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_ack: got ack at edge %0d, expected none", cyc);
      end else begin
        m = sb.pop_front();
        checkOutput("ack_data", dout_a, m.data);
        checkOutput("ack_latency", cyc, m.edge_no);
        checkOutput("ack_stall", {31'd0, stall_a}, 32'd0);
`ifdef DATA_RAM_RANGE_ERR_EN
        checkOutput("ack_err", {31'd0, err_a}, {31'd0, m.err});
`endif
      end
    end
  end

  task automatic accessB(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input int exp_edge, input logic [31:0] exp_data, input bit chk_data);
    bit got;
    ce_b = 1'b1; we_b = we; addr_b = addr; sel_b = 4'hF; data_b = data;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (ack_b) got = 1'b1;
    end
    if (!got) begin
      checks++; errors++;
      $display("[TB] FAIL b_ack_timeout: no ack at edge %0d, expected one at edge %0d", cyc, exp_edge);
    end else begin
      checkOutput("b_ack_edge", cyc, exp_edge);
      if (chk_data) checkOutput("b_load_data", dout_b, exp_data);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t;
    logic [31:0] upper, a;
    rst = 1'b1;
    ce_a = 0; we_a = 0; addr_a = 0; sel_a = 0; data_a = 0;
    ce_b = 0; we_b = 0; addr_b = 0; sel_b = 0; data_b = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ack", {31'd0, ack_a}, 32'd0);
    checkOutput("reset_data", dout_a, 32'd0);
    checkOutput("reset_stall", {31'd0, stall_a}, 32'd0);
`ifdef DATA_RAM_RANGE_ERR_EN
    checkOutput("reset_err", {31'd0, err_a}, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'(i * 4), 4'hF, $urandom, 1, 0);

    applyStimulus(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1, 0);
    applyStimulus(1'b0, 32'h10, 4'hF, 32'h0, 1, 0);
    checkOutput("load_deadbeef", dout_a, 32'hDEADBEEF);

    applyStimulus(1'b1, 32'h0, 4'hF, 32'h11223344, 1, 0);
    applyStimulus(1'b1, 32'h0, 4'b0100, 32'hAABBCCDD, 1, 0);
    applyStimulus(1'b0, 32'h0, 4'hF, 32'h0, 1, 0);
    checkOutput("byte_store", dout_a, 32'h11BB3344);

    applyStimulus(1'b1, 32'h8, 4'hF, 32'hFFFFFFFF, 1, 1);
    applyStimulus(1'b0, 32'h8, 4'hF, 32'h0, 1, 0);

    applyStimulus(1'b1, 32'h14, 4'h0, 32'hFFFFFFFF, 1, 0);
    applyStimulus(1'b0, 32'h14, 4'hF, 32'h0, 1, 0);

    applyStimulus(1'b1, 32'h18, 4'hF, 32'hA5A5A5A5, 1, 2);
    applyStimulus(1'b0, 32'h18, 4'hF, 32'h0, 1, 0);

    applyStimulus(1'b1, 32'h0001_0000, 4'hF, 32'h5A5A1234, 1, 0);
    applyStimulus(1'b0, 32'h0, 4'hF, 32'h0, 1, 0);

    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'(i * 4), 4'hF, 32'h0, 0, 0);

    repeat (150) begin
      upper = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 255)) : 32'h0;
      a = (upper << 12) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      applyStimulus(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom,
                    $urandom_range(0, 2), 0);
    end

    ce_a = 1'b0;
    repeat (W_A + 4) @(negedge clk);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    t = cyc + 1;
    accessB(1'b1, 32'h20, 32'hCAFEF00D, t, 32'h0, 1'b0);
    accessB(1'b1, 32'h24, 32'h12345678, t + 2, 32'h0, 1'b0);
    accessB(1'b0, 32'h20, 32'h0, t + 4, 32'hCAFEF00D, 1'b1);
    accessB(1'b0, 32'h24, 32'h0, t + 6, 32'h12345678, 1'b1);
    ce_b = 1'b0;
    @(negedge clk);
    checkOutput("b_ack_pulse", {31'd0, ack_b}, 32'd0);
    checkOutput("b_data_hold", dout_b, 32'h12345678);
`ifdef DATA_RAM_RANGE_ERR_EN
    checkOutput("b_err_idle", {31'd0, err_b}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
